// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider: one quotient bit per clock through a WIDTH+1-bit ripple subtractor.
// Optional signed mode enabled by defining DIV_SIGNED_EN (adds the div_signed input).
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             div_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_d, rem_d;
  logic             dbz_d;

  logic [WIDTH:0]   rs, sub_b, diff;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] q_it, r_it;

`ifdef DIV_SIGNED_EN
  logic neg_quot_q, neg_quot_d;
  logic neg_rem_q, neg_rem_d;
  logic dvd_neg, dvs_neg;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return (~x) + WIDTH'(1);
  endfunction
`endif

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  always_comb begin
    rs    = {r_q, q_q[WIDTH-1]};
    sub_b = ~{1'b0, d_q};
    carry = '0;
    diff  = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      diff[i]    = rs[i] ^ sub_b[i] ^ carry[i];
      carry[i+1] = (rs[i] & sub_b[i]) | (carry[i] & (rs[i] ^ sub_b[i]));
    end
    diff[WIDTH] = rs[WIDTH] ^ sub_b[WIDTH] ^ carry[WIDTH];
    q_it = {q_q[WIDTH-2:0], ~diff[WIDTH]};
    r_it = diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quot_d  = quotient;
    rem_d   = remainder;
    dbz_d   = div_by_zero;
`ifdef DIV_SIGNED_EN
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    dvd_neg    = div_signed & dividend[WIDTH-1];
    dvs_neg    = div_signed & divisor[WIDTH-1];
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef DIV_SIGNED_EN
          q_d        = dvd_neg ? negate(dividend) : dividend;
          d_d        = dvs_neg ? negate(divisor) : divisor;
          neg_quot_d = dvd_neg ^ dvs_neg;
          neg_rem_d  = dvd_neg;
`else
          q_d = dividend;
          d_d = divisor;
`endif
          r_d     = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // A zero divisor resolves on the first CALC cycle without iterating.
        if (d_q == '0) begin
          state_d = OUT;
          quot_d  = '1;
          dbz_d   = 1'b1;
`ifdef DIV_SIGNED_EN
          rem_d = neg_rem_q ? negate(q_q) : q_q;
`else
          rem_d = q_q;
`endif
        end else begin
          q_d   = q_it;
          r_d   = r_it;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = OUT;
            dbz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
            quot_d = neg_quot_q ? negate(q_it) : q_it;
            rem_d  = neg_rem_q ? negate(r_it) : r_it;
`else
            quot_d = q_it;
            rem_d  = r_it;
`endif
          end
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      d_q         <= d_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      in_ready    <= (state_d == IDLE);
      out_valid   <= (state_d == OUT);
      quotient    <= quot_d;
      remainder   <= rem_d;
      div_by_zero <= dbz_d;
`ifdef DIV_SIGNED_EN
      neg_quot_q  <= neg_quot_d;
      neg_rem_q   <= neg_rem_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider (WIDTH=8); signed cases run when DIV_SIGNED_EN is defined.
module tb_seq_restoring_divider;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;
`ifdef DIV_SIGNED_EN
  logic       div_signed;
`endif

  int vectors;
  int miscompares;

  seq_restoring_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV_SIGNED_EN
    .div_signed  (div_signed),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands for exactly one accept edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    dividend = 8'h5A;
    divisor  = 8'hA5;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int n;
    n = 1;
    while (out_valid !== 1'b1 && n < 40) begin
      chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
      step();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_in_ready_out"}, 32'(in_ready), 32'd0);
  endtask

  task automatic chk_result(input string tag, input logic [7:0] q, input logic [7:0] r, input logic z);
    chk({tag, "_quotient"}, 32'(quotient), 32'(q));
    chk({tag, "_remainder"}, 32'(remainder), 32'(r));
    chk({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(z));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b, input int lat,
                     input logic [7:0] q, input logic [7:0] r, input logic z);
    issue(a, b);
    wait_valid(tag, lat);
    chk_result(tag, q, r, z);
    handshake(tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    dividend    = '0;
    divisor     = '0;
`ifdef DIV_SIGNED_EN
    div_signed  = 1'b0;
`endif
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk_result("rst", 8'd0, 8'd0, 1'b0);
    rst_n = 1'b1;
    step();

    run("d100_7", 8'd100, 8'd7, 9, 8'd14, 8'd2, 1'b0);
    run("d255_1", 8'd255, 8'd1, 9, 8'd255, 8'd0, 1'b0);
    run("d3_200", 8'd3, 8'd200, 9, 8'd0, 8'd3, 1'b0);
    run("d5_0", 8'd5, 8'd0, 2, 8'hFF, 8'd5, 1'b1);

    // Back-pressure: result held while out_ready is low, new operands ignored.
    out_ready = 1'b0;
    issue(8'd200, 8'd9);
    wait_valid("d200_9", 9);
    chk_result("d200_9", 8'd22, 8'd2, 1'b0);
    in_valid = 1'b1;
    dividend = 8'd17;
    divisor  = 8'd4;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk_result("hold", 8'd22, 8'd2, 1'b0);
    end
    in_valid = 1'b0;
    handshake("d200_9");
    chk_result("idle_keep", 8'd22, 8'd2, 1'b0);

    // Reset during the fourth CALC cycle discards the division.
    issue(8'd77, 8'd3);
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk_result("midrst", 8'd0, 8'd0, 1'b0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    run("d77_3", 8'd77, 8'd3, 9, 8'd25, 8'd2, 1'b0);

    run("d255_255", 8'd255, 8'd255, 9, 8'd1, 8'd0, 1'b0);
    run("d13_50", 8'd13, 8'd50, 9, 8'd0, 8'd13, 1'b0);
    run("d0_9", 8'd0, 8'd9, 9, 8'd0, 8'd0, 1'b0);

`ifdef DIV_SIGNED_EN
    div_signed = 1'b1;
    run("s_m7_2", 8'hF9, 8'd2, 9, 8'hFD, 8'hFF, 1'b0);
    run("s_m128_m1", 8'h80, 8'hFF, 9, 8'h80, 8'h00, 1'b0);
    run("s_7_m2", 8'd7, 8'hFE, 9, 8'hFD, 8'h01, 1'b0);
    run("s_m5_0", 8'hFB, 8'd0, 2, 8'hFF, 8'hFB, 1'b1);
    div_signed = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
